// File: rtl/latch_bank_pkg.sv
// Shared types and helpers for the latch bank write controller.
// Optional macro LATCH_BANK_CLR_EN adds the CLR state to the state encoding.
package latch_bank_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        OPEN  = 3'd2,
`ifdef LATCH_BANK_CLR_EN
        HOLD  = 3'd3,
        CLR   = 3'd4
`else
        HOLD  = 3'd3
`endif
    } state_t;

    // Width of the gate-open cycle counter; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/latch_bank_wr_ctrl_if.sv
// Requester/latch-bank bus of the latch bank write controller.
// master: requester side (drives req, wdata, waddr[, clr_req]).
// slave : controller side (drives ack, busy, lat_d, lat_en[, lat_rst_n]).
// Optional macro LATCH_BANK_CLR_EN adds clr_req and lat_rst_n.
interface latch_bank_wr_ctrl_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned DW   = 8,
    parameter int unsigned AW   = 2
);
    localparam int unsigned NWORD = 1 << AW;

    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] wdata;
    logic [NREQ*AW-1:0] waddr;
    logic [NREQ-1:0]    ack;
    logic               busy;
    logic [DW-1:0]      lat_d;
    logic [NWORD-1:0]   lat_en;
`ifdef LATCH_BANK_CLR_EN
    logic               clr_req;
    logic               lat_rst_n;
`endif

    modport master (
`ifdef LATCH_BANK_CLR_EN
        output clr_req,
        input  lat_rst_n,
`endif
        output req, wdata, waddr,
        input  ack, busy, lat_d, lat_en
    );

    modport slave (
`ifdef LATCH_BANK_CLR_EN
        input  clr_req,
        output lat_rst_n,
`endif
        input  req, wdata, waddr,
        output ack, busy, lat_d, lat_en
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set req bit at or above ptr,
// wrapping modulo NREQ.
// Ports: req (requests), ptr (search start), grant (onehot0), idx (binary).
module rr_pick #(
    parameter int unsigned NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         grant,
    output logic [$clog2(NREQ)-1:0] idx
);
    localparam int unsigned IW = $clog2(NREQ);

    logic        found;
    int unsigned k;

    // Scan NREQ positions starting at ptr; the first hit wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        k     = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            k = (32'(ptr) + i) % NREQ;
            if (!found && req[k]) begin
                found    = 1'b1;
                grant[k] = 1'b1;
                idx      = IW'(k);
            end
        end
    end

endmodule

// File: rtl/latch_bank_wr_ctrl.sv
// Round-robin write controller for a bank of level-sensitive latch words.
// Each write runs SETUP -> OPEN (OPEN_CYC cycles) -> HOLD so lat_d is
// stable around the gate pulse, followed by a mandatory IDLE cycle.
// Ports: clk, rst (sync, active-high), bus (slave modport: req/wdata/waddr
// in; ack/busy/lat_d/lat_en out, all registered).
// Optional macro LATCH_BANK_CLR_EN adds clr_req/lat_rst_n and a CLR state.
module latch_bank_wr_ctrl
    import latch_bank_pkg::*;
#(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned DW       = 8,
    parameter int unsigned AW       = 2,
    parameter int unsigned OPEN_CYC = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    latch_bank_wr_ctrl_if.slave  bus
);
    localparam int unsigned NWORD = 1 << AW;
    localparam int unsigned IW    = $clog2(NREQ);
    localparam int unsigned CW    = cnt_width(OPEN_CYC);

    if (OPEN_CYC < 1) begin : g_open_cyc_chk
        $error("latch_bank_wr_ctrl: OPEN_CYC must be at least 1");
    end

    state_t           state;
    logic [IW-1:0]    rr_ptr;
    logic [IW-1:0]    win_idx;
    logic [NREQ-1:0]  win_oh;
    logic [AW-1:0]    cap_addr;
    logic [CW-1:0]    cnt;
    logic [NREQ-1:0]  pick_grant;
    logic [IW-1:0]    pick_idx;

    logic [NREQ-1:0]  ack;
    logic             busy;
    logic [DW-1:0]    lat_d;
    logic [NWORD-1:0] lat_en;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req   (bus.req),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .idx   (pick_idx)
    );

    // Write sequencer; lat_d doubles as the captured data register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            win_idx  <= '0;
            win_oh   <= '0;
            cap_addr <= '0;
            cnt      <= '0;
            ack      <= '0;
            busy     <= 1'b0;
            lat_d    <= '0;
            lat_en   <= '0;
`ifdef LATCH_BANK_CLR_EN
            bus.lat_rst_n <= 1'b0;
`endif
        end else begin
            ack <= '0;
`ifdef LATCH_BANK_CLR_EN
            bus.lat_rst_n <= 1'b1;
`endif
            case (state)
                IDLE: begin
`ifdef LATCH_BANK_CLR_EN
                    if (bus.clr_req) begin
                        state         <= CLR;
                        busy          <= 1'b1;
                        bus.lat_rst_n <= 1'b0;
                    end else
`endif
                    if (|bus.req) begin
                        state    <= SETUP;
                        busy     <= 1'b1;
                        win_idx  <= pick_idx;
                        win_oh   <= pick_grant;
                        lat_d    <= bus.wdata[32'(pick_idx)*DW +: DW];
                        cap_addr <= bus.waddr[32'(pick_idx)*AW +: AW];
                    end
                end
                SETUP: begin
                    state  <= OPEN;
                    cnt    <= '0;
                    lat_en <= NWORD'(1) << cap_addr;
                end
                OPEN: begin
                    if (cnt == CW'(OPEN_CYC - 1)) begin
                        state  <= HOLD;
                        lat_en <= '0;
                        ack    <= win_oh;
                        rr_ptr <= IW'((32'(win_idx) + 32'd1) % NREQ);
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                HOLD: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
`ifdef LATCH_BANK_CLR_EN
                CLR: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
`endif
                default: begin
                    state  <= IDLE;
                    busy   <= 1'b0;
                    lat_en <= '0;
                end
            endcase
        end
    end

    assign bus.ack    = ack;
    assign bus.busy   = busy;
    assign bus.lat_d  = lat_d;
    assign bus.lat_en = lat_en;

endmodule

// File: tb/tb_latch_bank_wr_ctrl.sv
// Directed self-checking bench for latch_bank_wr_ctrl (OPEN_CYC=1 and 3).
// Cycle n is the interval just after the n-th observed rising edge; inputs
// are driven and outputs sampled 1 time unit after the edge.
// Optional macro LATCH_BANK_CLR_EN enables the clear scenario.
module tb_latch_bank_wr_ctrl;
    localparam int unsigned NREQ = 4;
    localparam int unsigned DW   = 8;
    localparam int unsigned AW   = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    latch_bank_wr_ctrl_if #(.NREQ(NREQ), .DW(DW), .AW(AW)) bus1 ();
    latch_bank_wr_ctrl_if #(.NREQ(NREQ), .DW(DW), .AW(AW)) bus3 ();

    latch_bank_wr_ctrl #(.NREQ(NREQ), .DW(DW), .AW(AW), .OPEN_CYC(1)) dut1 (
        .clk (clk), .rst (rst), .bus (bus1.slave)
    );
    latch_bank_wr_ctrl #(.NREQ(NREQ), .DW(DW), .AW(AW), .OPEN_CYC(3)) dut3 (
        .clk (clk), .rst (rst), .bus (bus3.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus1.req = '0; bus1.wdata = '0; bus1.waddr = '0;
        bus3.req = '0; bus3.wdata = '0; bus3.waddr = '0;
`ifdef LATCH_BANK_CLR_EN
        bus1.clr_req = 1'b0;
        bus3.clr_req = 1'b0;
`endif
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    // Bounded wait for an ack on bus1; a timeout returns a=0.
    task automatic wait_ack1(input int max, output logic [NREQ-1:0] a,
                             output int n, output logic [3:0] en_or);
        a = '0; n = 0; en_or = '0;
        while (n < max && a == '0) begin
            tick();
            n++;
            en_or |= bus1.lat_en;
            if (bus1.ack != '0) a = bus1.ack;
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (bus1.ack !== 4'b0) begin failures++; $display("FAIL reset_ack got=%b exp=0000", bus1.ack); end
        checks++; if (bus1.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus1.busy); end
        checks++; if (bus1.lat_d !== 8'h00) begin failures++; $display("FAIL reset_lat_d got=%h exp=00", bus1.lat_d); end
        checks++; if (bus1.lat_en !== 4'b0) begin failures++; $display("FAIL reset_lat_en got=%b exp=0000", bus1.lat_en); end
        checks++; if (bus3.lat_en !== 4'b0) begin failures++; $display("FAIL reset_lat_en3 got=%b exp=0000", bus3.lat_en); end
`ifdef LATCH_BANK_CLR_EN
        tick();
        checks++; if (bus1.lat_rst_n !== 1'b0) begin failures++; $display("FAIL reset_lat_rst_n got=%b exp=0", bus1.lat_rst_n); end
`endif
        rst = 1'b0;
        tick();
`ifdef LATCH_BANK_CLR_EN
        checks++; if (bus1.lat_rst_n !== 1'b1) begin failures++; $display("FAIL release_lat_rst_n got=%b exp=1", bus1.lat_rst_n); end
`endif
    endtask

    task automatic test_single_write();
        do_reset();
        bus1.waddr[1*AW +: AW] = 2'd2;
        bus1.wdata[1*DW +: DW] = 8'hA5;
        bus1.req = 4'b0010;
        tick(); // cycle 1: SETUP
        checks++; if (bus1.lat_d !== 8'hA5) begin failures++; $display("FAIL sw_c1_lat_d got=%h exp=a5", bus1.lat_d); end
        checks++; if (bus1.lat_en !== 4'b0000) begin failures++; $display("FAIL sw_c1_lat_en got=%b exp=0000", bus1.lat_en); end
        checks++; if (bus1.busy !== 1'b1) begin failures++; $display("FAIL sw_c1_busy got=%b exp=1", bus1.busy); end
        // late data/address changes must be ignored
        bus1.wdata[1*DW +: DW] = 8'h3C;
        bus1.waddr[1*AW +: AW] = 2'd0;
        tick(); // cycle 2: OPEN
        checks++; if (bus1.lat_en !== 4'b0100) begin failures++; $display("FAIL sw_c2_lat_en got=%b exp=0100", bus1.lat_en); end
        checks++; if (bus1.lat_d !== 8'hA5) begin failures++; $display("FAIL sw_c2_lat_d got=%h exp=a5", bus1.lat_d); end
        checks++; if (bus1.ack !== 4'b0000) begin failures++; $display("FAIL sw_c2_ack got=%b exp=0000", bus1.ack); end
        tick(); // cycle 3: HOLD
        checks++; if (bus1.ack !== 4'b0010) begin failures++; $display("FAIL sw_c3_ack got=%b exp=0010", bus1.ack); end
        checks++; if (bus1.lat_en !== 4'b0000) begin failures++; $display("FAIL sw_c3_lat_en got=%b exp=0000", bus1.lat_en); end
        checks++; if (bus1.busy !== 1'b1) begin failures++; $display("FAIL sw_c3_busy got=%b exp=1", bus1.busy); end
        checks++; if (bus1.lat_d !== 8'hA5) begin failures++; $display("FAIL sw_c3_lat_d got=%h exp=a5", bus1.lat_d); end
        bus1.req = 4'b0000;
        tick(); // cycle 4: IDLE
        checks++; if (bus1.busy !== 1'b0) begin failures++; $display("FAIL sw_c4_busy got=%b exp=0", bus1.busy); end
        checks++; if (bus1.ack !== 4'b0000) begin failures++; $display("FAIL sw_c4_ack got=%b exp=0000", bus1.ack); end
        checks++; if (bus1.lat_d !== 8'hA5) begin failures++; $display("FAIL sw_c4_lat_d got=%h exp=a5", bus1.lat_d); end
        tick();
        checks++; if (bus1.busy !== 1'b0) begin failures++; $display("FAIL sw_c5_busy got=%b exp=0", bus1.busy); end
    endtask

    task automatic test_contention();
        logic [NREQ-1:0] a;
        logic [3:0]      en;
        int              n;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            bus1.wdata[i*DW +: DW] = 8'(8'h10 + i);
            bus1.waddr[i*AW +: AW] = AW'(i);
        end
        bus1.req = 4'b1111;
        for (int g = 0; g < 4; g++) begin
            wait_ack1(12, a, n, en);
            checks++; if (a !== (4'(1) << g)) begin failures++; $display("FAIL cont_grant%0d got=%b exp=%b", g, a, 4'(1) << g); end
            checks++; if (en !== (4'(1) << g)) begin failures++; $display("FAIL cont_lat_en%0d got=%b exp=%b", g, en, 4'(1) << g); end
            checks++; if (bus1.lat_d !== 8'(8'h10 + g)) begin failures++; $display("FAIL cont_lat_d%0d got=%h exp=%h", g, bus1.lat_d, 8'(8'h10 + g)); end
            checks++; if (n !== ((g == 0) ? 3 : 4)) begin failures++; $display("FAIL cont_spacing%0d got=%0d exp=%0d", g, n, (g == 0) ? 3 : 4); end
            bus1.req[g] = 1'b0;
        end
        bus1.req = 4'b1001;
        wait_ack1(12, a, n, en);
        checks++; if (a !== 4'b0001) begin failures++; $display("FAIL cont_wrap_grant got=%b exp=0001", a); end
        checks++; if (n !== 4) begin failures++; $display("FAIL cont_wrap_spacing got=%0d exp=4", n); end
        bus1.req = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_fairness();
        logic [NREQ-1:0] a;
        logic [3:0]      en;
        int              n;
        int              exp_idx [4] = '{0, 2, 0, 2};
        logic [3:0]      exp_en;
        do_reset();
        bus1.waddr[0*AW +: AW] = 2'd3;
        bus1.waddr[2*AW +: AW] = 2'd1;
        bus1.wdata[0*DW +: DW] = 8'h11;
        bus1.wdata[2*DW +: DW] = 8'h22;
        bus1.req = 4'b0101;
        for (int k = 0; k < 4; k++) begin
            exp_en = (exp_idx[k] == 0) ? 4'b1000 : 4'b0010;
            wait_ack1(12, a, n, en);
            checks++; if (a !== (4'(1) << exp_idx[k])) begin failures++; $display("FAIL fair_grant%0d got=%b exp=%b", k, a, 4'(1) << exp_idx[k]); end
            checks++; if (en !== exp_en) begin failures++; $display("FAIL fair_lat_en%0d got=%b exp=%b", k, en, exp_en); end
            checks++; if (n !== ((k == 0) ? 3 : 4)) begin failures++; $display("FAIL fair_spacing%0d got=%0d exp=%0d", k, n, (k == 0) ? 3 : 4); end
        end
        bus1.req = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_open_cyc3();
        int              first_en = -1;
        int              last_en  = -1;
        int              en_cnt   = 0;
        int              bad_en   = 0;
        int              ack_at   = -1;
        logic [NREQ-1:0] ackv     = '0;
        do_reset();
        bus3.waddr[0 +: AW] = 2'd2;
        bus3.wdata[0 +: DW] = 8'h5A;
        bus3.req = 4'b0001;
        for (int t = 1; t <= 10; t++) begin
            tick();
            if (bus3.lat_en == 4'b0100) begin
                en_cnt++;
                if (first_en < 0) first_en = t;
                last_en = t;
            end else if (bus3.lat_en != 4'b0000) begin
                bad_en++;
            end
            if (bus3.ack != '0 && ack_at < 0) begin
                ack_at = t;
                ackv = bus3.ack;
                bus3.req = 4'b0000;
            end
        end
        checks++; if (en_cnt !== 3) begin failures++; $display("FAIL oc3_en_cycles got=%0d exp=3", en_cnt); end
        checks++; if (first_en !== 2 || last_en !== 4) begin failures++; $display("FAIL oc3_en_window got=%0d..%0d exp=2..4", first_en, last_en); end
        checks++; if (bad_en !== 0) begin failures++; $display("FAIL oc3_bad_en got=%0d exp=0", bad_en); end
        checks++; if (ack_at !== 5) begin failures++; $display("FAIL oc3_ack_cycle got=%0d exp=5", ack_at); end
        checks++; if (ackv !== 4'b0001) begin failures++; $display("FAIL oc3_ack got=%b exp=0001", ackv); end
        checks++; if (bus3.lat_d !== 8'h5A) begin failures++; $display("FAIL oc3_lat_d got=%h exp=5a", bus3.lat_d); end
    endtask

    task automatic test_reset_mid_write();
        logic [NREQ-1:0] a;
        logic [3:0]      en;
        int              n;
        do_reset();
        bus1.waddr[0 +: AW] = 2'd1;
        bus1.wdata[0 +: DW] = 8'h77;
        bus1.req = 4'b0001;
        tick(); // SETUP
        tick(); // OPEN
        checks++; if (bus1.lat_en !== 4'b0010) begin failures++; $display("FAIL rmw_open_lat_en got=%b exp=0010", bus1.lat_en); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (bus1.lat_en !== 4'b0000) begin failures++; $display("FAIL rmw_lat_en got=%b exp=0000", bus1.lat_en); end
        checks++; if (bus1.busy !== 1'b0) begin failures++; $display("FAIL rmw_busy got=%b exp=0", bus1.busy); end
        checks++; if (bus1.ack !== 4'b0000) begin failures++; $display("FAIL rmw_ack got=%b exp=0000", bus1.ack); end
        wait_ack1(10, a, n, en);
        checks++; if (a !== 4'b0001) begin failures++; $display("FAIL rmw_regrant got=%b exp=0001", a); end
        checks++; if (n !== 3) begin failures++; $display("FAIL rmw_regrant_lat got=%0d exp=3", n); end
        checks++; if (bus1.lat_d !== 8'h77) begin failures++; $display("FAIL rmw_lat_d got=%h exp=77", bus1.lat_d); end
        bus1.req = 4'b0000;
        tick();
    endtask

`ifdef LATCH_BANK_CLR_EN
    task automatic test_clear();
        logic [NREQ-1:0] a;
        logic [3:0]      en;
        int              n;
        do_reset();
        bus1.waddr[0 +: AW] = 2'd0;
        bus1.wdata[0 +: DW] = 8'h99;
        bus1.clr_req = 1'b1;
        bus1.req = 4'b0001;
        tick(); // CLR
        checks++; if (bus1.lat_rst_n !== 1'b0) begin failures++; $display("FAIL clr_lat_rst_n got=%b exp=0", bus1.lat_rst_n); end
        checks++; if (bus1.lat_en !== 4'b0000) begin failures++; $display("FAIL clr_lat_en got=%b exp=0000", bus1.lat_en); end
        checks++; if (bus1.ack !== 4'b0000) begin failures++; $display("FAIL clr_ack got=%b exp=0000", bus1.ack); end
        checks++; if (bus1.busy !== 1'b1) begin failures++; $display("FAIL clr_busy got=%b exp=1", bus1.busy); end
        bus1.clr_req = 1'b0;
        tick(); // IDLE
        checks++; if (bus1.lat_rst_n !== 1'b1) begin failures++; $display("FAIL clr_done_lat_rst_n got=%b exp=1", bus1.lat_rst_n); end
        checks++; if (bus1.ack !== 4'b0000) begin failures++; $display("FAIL clr_done_ack got=%b exp=0000", bus1.ack); end
        wait_ack1(10, a, n, en);
        checks++; if (a !== 4'b0001) begin failures++; $display("FAIL clr_then_grant got=%b exp=0001", a); end
        checks++; if (n !== 3) begin failures++; $display("FAIL clr_then_lat got=%0d exp=3", n); end
        bus1.req = 4'b0000;
        tick();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_write();
        test_contention();
        test_fairness();
        test_open_cyc3();
        test_reset_mid_write();
`ifdef LATCH_BANK_CLR_EN
        test_clear();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
